reu_regs: RTL and testbench
===========================

Name: reu_regs

Overview:
- REC-compatible REU register file for the C64 cartridge CPLD, mapped at $DF00-$DF1F and mirrored every 32 bytes through $DFFF.
- Sits directly upstream of the DMA sequencer:
  - drives Execute, XferType and Length1 to the sequencer;
  - consumes the sequencer's IncCA, DecLen, IncREUA, XferEnd, SetEndOfBlock and SetVerifyErr strobes.
- Holds the working and shadow (autoload) C64 address, REU address and length.
- Drives the C64 address (CA) and REU address (REUA) busses.

Parameters:
BANK_BITS, 3, REU bank register width in bits; the REU address is 16+BANK_BITS wide (3 = 512 KB).
SIZE_BIT, 1, value returned in status bit 4 (1 = 256 Kbit RAM chips).
VERSION, 0, value returned in status bits 3:0.

Ports:
PHI2  in  1  C64 PHI2. All state changes on negedge PHI2.
nRESET  in  1  Asynchronous, active-low reset. The top level drives it from !RegReset.
nIO2  in  1  Active-low select for $DF00-$DFFF.
A  in  5  Register offset (C64 A4:A0).
RnW  in  1  C64 R/W.
Din  in  8  C64 data bus in.
Dout  out  8  Register read data (combinational).
DOE  out  1  Data output enable: !nIO2 && RnW && !DMA.
FF00Wr  in  1  CPU write to $FF00 decoded by the top level; valid at negedge.
DMA  in  1  DMA active, from the sequencer.
Execute  out  1  Start transfer, to the sequencer.
XferType  out  2  Command bits 1:0.
Length1  out  1  Length register == 1.
IncCA, DecLen, IncREUA, XferEnd, SetEndOfBlock, SetVerifyErr  in  1 each  Sequencer strobes.
CA  out  16  Working C64 address.
REUA  out  16+BANK_BITS  Working REU address.
nIRQ  out  1  Active-low interrupt to the C64 bus.

Behaviour:
- Reset values:
  - command = $10;
  - CA/REUA and their shadows = 0;
  - length and shadow = $FFFF;
  - IRQ mask = 0, address control = 0, status flags = 0;
  - Armed = 0, Execute = 0, nIRQ = 1.
- Register write: occurs at negedge when !nIO2 && !RnW && !DMA.
  - $02-$08 writes the working copy and the shadow copy together.
  - A register write has priority over a same-edge Inc/Dec strobe (this cannot occur in practice because writes are gated by !DMA).
- Register map:
  - 00 status (R);
  - 01 command: b7 execute, b5 autoload, b4 FF00-disable, b1:0 type;
  - 02/03 CA lo/hi;
  - 04/05/06 REUA lo/hi/bank;
  - 07/08 length lo/hi;
  - 09 IRQ mask: b7 enable, b6 EOB, b5 verify;
  - 0A address control: b7 fix CA, b6 fix REUA;
  - 0B-1F read $FF.
- Read-back of unused bits:
  - unused bits of 06, 09 and 0A read 1;
  - unused bits 3 and 2 of 01 read 1.
- Status byte: b7 IRQ pending, b6 end-of-block, b5 verify error, b4 SIZE_BIT, b3:0 VERSION.
- Status read side effect: a read of status (negedge with !nIO2, RnW, A=0, !DMA) clears b7:5.
  - If a set and a clear occur on the same edge, the set wins.
- Status set rules:
  - EOB is set when SetEndOfBlock = 1.
  - Verify error is set when SetVerifyErr = 1.
  - Both flags are sticky.
- Interrupt:
  - IRQ pending = mask.b7 && ((mask.b6 && EOB) || (mask.b5 && VERR)).
  - IRQ pending is recomputed combinationally from the stored flags.
  - nIRQ = !pending.
- Execute trigger:
  - A command write with b7=1 and b4=1 sets Execute at the same edge.
  - A command write with b7=1 and b4=0 sets Armed.
  - FF00Wr while Armed sets Execute and clears Armed.
  - A command write with b7=0 clears Armed.
- Transfer end: on a negedge with XferEnd=1:
  - Execute <= 0;
  - command b7 <= 0 and b4 <= 1;
  - if autoload, CA, REUA and length reload from their shadows.
- Execute is therefore low on the same edge at which the sequencer drops DMA.
- Counters:
  - IncCA increments CA unless fix-CA is set; wraps $FFFF->$0000.
  - IncREUA increments REUA unless fix-REUA is set; wraps modulo 2^(16+BANK_BITS), carrying across the bank.
  - DecLen decrements length by 1. Length 0 means 65536: 0 decrements to $FFFF. The sequencer never decrements from 1.
- XferEnd with an Inc/Dec strobe on the same edge:
  - with autoload, the reload wins;
  - without autoload, the increment/decrement applies.
- Length1 = (length == 1), combinational.
- Reset asserted mid-transfer: all state returns to reset values immediately (asynchronous).

Decomposition:
- Package reu_pkg holds:
  - register offset constants;
  - XFER_C64REU/REUC64/SWAP/VERIFY codes (00/01/10/11);
  - status, command, mask and control bit positions.
- Sub-module reu_shadow_counter: parameter WIDTH; byte-lane write into working and shadow, inc/dec enables, reload input. Instantiated for CA (up), REUA (up) and length (down).

Test Plan:
- Write 01=$90 (type 00, immediate) -> Execute=1 after that negedge; XferType=00.
- Write 01=$81, then FF00Wr -> Execute stays 0 until the FF00Wr edge, then goes to 1; Armed clears.
- Length=$0002, CA=$C000, pulse DecLen+IncCA once -> Length1=1, CA=$C001; then XferEnd -> Execute=0, 01 reads $10|type|$0C.
- Autoload set, REUA=$07FFFF, 3 IncREUA then XferEnd -> REUA wraps through $000000 to $000002, then reloads to $07FFFF.
- Mask $E0, pulse SetVerifyErr -> nIRQ=0 and status reads $B0; the next status read returns $10 and nIRQ=1.
- Fix-CA=1 with IncCA pulses -> CA unchanged. Assert nRESET low mid-transfer -> Execute=0 and length=$FFFF immediately.

Source files
------------

// File: rtl/reu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reu_pkg
// Description : REU register offsets, transfer codes and register bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package reu_pkg;

    localparam logic [4:0] c_REG_STATUS    = 5'h00;
    localparam logic [4:0] c_REG_COMMAND   = 5'h01;
    localparam logic [4:0] c_REG_CA_LO     = 5'h02;
    localparam logic [4:0] c_REG_CA_HI     = 5'h03;
    localparam logic [4:0] c_REG_REUA_LO   = 5'h04;
    localparam logic [4:0] c_REG_REUA_HI   = 5'h05;
    localparam logic [4:0] c_REG_REUA_BANK = 5'h06;
    localparam logic [4:0] c_REG_LEN_LO    = 5'h07;
    localparam logic [4:0] c_REG_LEN_HI    = 5'h08;
    localparam logic [4:0] c_REG_IRQ_MASK  = 5'h09;
    localparam logic [4:0] c_REG_ADDR_CTRL = 5'h0A;

    typedef enum logic [1:0] {
        XFER_C64REU = 2'b00,
        XFER_REUC64 = 2'b01,
        XFER_SWAP   = 2'b10,
        XFER_VERIFY = 2'b11
    } xfer_t;

    localparam int c_ST_IRQ        = 7;
    localparam int c_ST_EOB        = 6;
    localparam int c_ST_VERR       = 5;
    localparam int c_CMD_EXEC      = 7;
    localparam int c_CMD_AUTOLOAD  = 5;
    localparam int c_CMD_FF00DIS   = 4;
    localparam int c_MASK_EN       = 7;
    localparam int c_MASK_EOB      = 6;
    localparam int c_MASK_VERR     = 5;
    localparam int c_CTRL_FIXCA    = 7;
    localparam int c_CTRL_FIXREUA  = 6;

endpackage
`default_nettype wire

// File: rtl/reu_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : reu_regs_if
// Description : C64 I/O2 register bus between the cartridge bus and reu_regs.
// Revision    : 1.0 - initial release
// ============================================================================
interface reu_regs_if;
    logic       nIO2;
    logic [4:0] A;
    logic       RnW;
    logic [7:0] Din;
    logic [7:0] Dout;
    logic       DOE;

    modport master (output nIO2, A, RnW, Din, input Dout, DOE);
    modport slave  (input nIO2, A, RnW, Din, output Dout, DOE);
endinterface
`default_nettype wire

// File: rtl/reu_shadow_counter.sv
`default_nettype none
// ============================================================================
// Module      : reu_shadow_counter
// Description : Byte-writable counter with an autoload shadow copy.
// Revision    : 1.0 - initial release
// ============================================================================
module reu_shadow_counter #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic [(WIDTH+7)/8-1:0]     wrLane,
    input  wire logic [7:0]                 wrData,
    input  wire logic                       inc,
    input  wire logic                       dec,
    input  wire logic                       reload,
    output logic      [WIDTH-1:0]           value,
    output logic      [WIDTH-1:0]           shadow
);

    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_wrMask;
    logic [WIDTH-1:0] w_wrVal;

    always_comb begin
        w_wrMask = '0;
        w_wrVal  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_wrMask[i] = wrLane[i / 8];
            w_wrVal[i]  = wrData[i % 8];
        end
    end

    // Register state advances on the falling edge of the bus clock.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value  <= RESET_VAL;
            r_shadow <= RESET_VAL;
        end else if (|wrLane) begin
            r_value  <= (r_value  & ~w_wrMask) | (w_wrVal & w_wrMask);
            r_shadow <= (r_shadow & ~w_wrMask) | (w_wrVal & w_wrMask);
        end else if (reload) begin
            r_value  <= r_shadow;
        end else if (inc) begin
            r_value  <= r_value + WIDTH'(1);
        end else if (dec) begin
            r_value  <= r_value - WIDTH'(1);
        end
    end

    assign value  = r_value;
    assign shadow = r_shadow;

endmodule
`default_nettype wire

// File: rtl/reu_regs.sv
`default_nettype none
// ============================================================================
// Module      : reu_regs
// Description : REC-compatible REU register file at $DF00-$DF1F (mirrored).
// Revision    : 1.0 - initial release
// ============================================================================
module reu_regs
    import reu_pkg::*;
#(
    parameter int         BANK_BITS = 3,
    parameter logic       SIZE_BIT  = 1'b1,
    parameter logic [3:0] VERSION   = 4'd0
) (
    input  wire logic                    PHI2,
    input  wire logic                    nRESET,
    reu_regs_if.slave                    bus,
    input  wire logic                    FF00Wr,
    input  wire logic                    DMA,
    output logic                         Execute,
    output logic [1:0]                   XferType,
    output logic                         Length1,
    input  wire logic                    IncCA,
    input  wire logic                    DecLen,
    input  wire logic                    IncREUA,
    input  wire logic                    XferEnd,
    input  wire logic                    SetEndOfBlock,
    input  wire logic                    SetVerifyErr,
    output logic [15:0]                  CA,
    output logic [16+BANK_BITS-1:0]      REUA,
    output logic                         nIRQ
);

    logic        r_execute;
    logic        r_armed;
    logic        r_cmdExec;
    logic        r_autoload;
    logic        r_ff00Dis;
    xfer_t       r_xferType;
    logic        r_maskEn;
    logic        r_maskEob;
    logic        r_maskVerr;
    logic        r_fixCA;
    logic        r_fixREUA;
    logic        r_eob;
    logic        r_verr;

    logic        w_regWr;
    logic        w_statusRd;
    logic [10:1] w_wrSel;
    logic        w_pending;
    logic        w_reload;
    logic [7:0]  w_bankByte;
    logic [15:0] w_length;
    logic [15:0] w_caShadow;
    logic [15:0] w_lenShadow;
    logic [16+BANK_BITS-1:0] w_reuaShadow;

    assign w_regWr    = !bus.nIO2 && !bus.RnW && !DMA;
    assign w_statusRd = !bus.nIO2 &&  bus.RnW && !DMA && (bus.A == c_REG_STATUS);
    assign w_reload   = XferEnd && r_autoload;

    always_comb begin
        w_wrSel = '0;
        for (int i = 1; i <= 10; i++) begin
            w_wrSel[i] = w_regWr && (bus.A == 5'(i));
        end
    end

    reu_shadow_counter #(.WIDTH(16), .RESET_VAL(16'h0000)) u_ca (
        .clk    (PHI2),
        .rst_n  (nRESET),
        .wrLane ({w_wrSel[c_REG_CA_HI], w_wrSel[c_REG_CA_LO]}),
        .wrData (bus.Din),
        .inc    (IncCA && !r_fixCA),
        .dec    (1'b0),
        .reload (w_reload),
        .value  (CA),
        .shadow (w_caShadow)
    );

    reu_shadow_counter #(.WIDTH(16+BANK_BITS), .RESET_VAL('0)) u_reua (
        .clk    (PHI2),
        .rst_n  (nRESET),
        .wrLane ({w_wrSel[c_REG_REUA_BANK], w_wrSel[c_REG_REUA_HI], w_wrSel[c_REG_REUA_LO]}),
        .wrData (bus.Din),
        .inc    (IncREUA && !r_fixREUA),
        .dec    (1'b0),
        .reload (w_reload),
        .value  (REUA),
        .shadow (w_reuaShadow)
    );

    // Length 0 stands for 65536, so plain modulo decrement is correct.
    reu_shadow_counter #(.WIDTH(16), .RESET_VAL(16'hFFFF)) u_len (
        .clk    (PHI2),
        .rst_n  (nRESET),
        .wrLane ({w_wrSel[c_REG_LEN_HI], w_wrSel[c_REG_LEN_LO]}),
        .wrData (bus.Din),
        .inc    (1'b0),
        .dec    (DecLen),
        .reload (w_reload),
        .value  (w_length),
        .shadow (w_lenShadow)
    );

    always_ff @(negedge PHI2 or negedge nRESET) begin
        if (!nRESET) begin
            r_execute  <= 1'b0;
            r_armed    <= 1'b0;
            r_cmdExec  <= 1'b0;
            r_autoload <= 1'b0;
            r_ff00Dis  <= 1'b1;
            r_xferType <= XFER_C64REU;
        end else begin
            if (w_wrSel[c_REG_COMMAND]) begin
                r_cmdExec  <= bus.Din[c_CMD_EXEC];
                r_autoload <= bus.Din[c_CMD_AUTOLOAD];
                r_ff00Dis  <= bus.Din[c_CMD_FF00DIS];
                r_xferType <= xfer_t'(bus.Din[1:0]);
                if (bus.Din[c_CMD_EXEC] && bus.Din[c_CMD_FF00DIS]) begin
                    r_execute <= 1'b1;
                    r_armed   <= 1'b0;
                end else begin
                    r_armed   <= bus.Din[c_CMD_EXEC];
                end
            end else if (FF00Wr && r_armed) begin
                r_execute <= 1'b1;
                r_armed   <= 1'b0;
            end
            // End of transfer drops Execute on the same edge the sequencer drops DMA.
            if (XferEnd) begin
                r_execute <= 1'b0;
                r_cmdExec <= 1'b0;
                r_ff00Dis <= 1'b1;
            end
        end
    end

    always_ff @(negedge PHI2 or negedge nRESET) begin
        if (!nRESET) begin
            r_maskEn   <= 1'b0;
            r_maskEob  <= 1'b0;
            r_maskVerr <= 1'b0;
            r_fixCA    <= 1'b0;
            r_fixREUA  <= 1'b0;
            r_eob      <= 1'b0;
            r_verr     <= 1'b0;
        end else begin
            if (w_wrSel[c_REG_IRQ_MASK]) begin
                r_maskEn   <= bus.Din[c_MASK_EN];
                r_maskEob  <= bus.Din[c_MASK_EOB];
                r_maskVerr <= bus.Din[c_MASK_VERR];
            end
            if (w_wrSel[c_REG_ADDR_CTRL]) begin
                r_fixCA    <= bus.Din[c_CTRL_FIXCA];
                r_fixREUA  <= bus.Din[c_CTRL_FIXREUA];
            end
            if (w_statusRd) begin
                r_eob  <= 1'b0;
                r_verr <= 1'b0;
            end
            if (SetEndOfBlock) r_eob  <= 1'b1;
            if (SetVerifyErr)  r_verr <= 1'b1;
        end
    end

    assign w_pending = r_maskEn && ((r_maskEob && r_eob) || (r_maskVerr && r_verr));

    always_comb begin
        w_bankByte                  = 8'hFF;
        w_bankByte[BANK_BITS-1:0]   = REUA[16 +: BANK_BITS];
        case (bus.A)
            c_REG_STATUS:    bus.Dout = {w_pending, r_eob, r_verr, SIZE_BIT, VERSION};
            c_REG_COMMAND:   bus.Dout = {r_cmdExec, 1'b0, r_autoload, r_ff00Dis, 2'b11, r_xferType};
            c_REG_CA_LO:     bus.Dout = CA[7:0];
            c_REG_CA_HI:     bus.Dout = CA[15:8];
            c_REG_REUA_LO:   bus.Dout = REUA[7:0];
            c_REG_REUA_HI:   bus.Dout = REUA[15:8];
            c_REG_REUA_BANK: bus.Dout = w_bankByte;
            c_REG_LEN_LO:    bus.Dout = w_length[7:0];
            c_REG_LEN_HI:    bus.Dout = w_length[15:8];
            c_REG_IRQ_MASK:  bus.Dout = {r_maskEn, r_maskEob, r_maskVerr, 5'b11111};
            c_REG_ADDR_CTRL: bus.Dout = {r_fixCA, r_fixREUA, 6'b111111};
            default:         bus.Dout = 8'hFF;
        endcase
    end

    assign bus.DOE  = !bus.nIO2 && bus.RnW && !DMA;
    assign Execute  = r_execute;
    assign XferType = r_xferType;
    assign Length1  = (w_length == 16'h0001);
    assign nIRQ     = !w_pending;

endmodule
`default_nettype wire

// File: tb/tb_reu_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_reu_regs
// Description : Directed self-checking bench for reu_regs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reu_regs;

    logic        PHI2 = 1'b1;
    logic        nRESET, FF00Wr, DMA;
    logic        IncCA, DecLen, IncREUA, XferEnd, SetEndOfBlock, SetVerifyErr;
    logic        Execute, Length1, nIRQ;
    logic [1:0]  XferType;
    logic [15:0] CA;
    logic [18:0] REUA;
    int          nChecks = 0;
    int          nFails  = 0;

    reu_regs_if bus ();

    reu_regs #(.BANK_BITS(3), .SIZE_BIT(1'b1), .VERSION(4'd0)) dut (
        .PHI2          (PHI2),
        .nRESET        (nRESET),
        .bus           (bus),
        .FF00Wr        (FF00Wr),
        .DMA           (DMA),
        .Execute       (Execute),
        .XferType      (XferType),
        .Length1       (Length1),
        .IncCA         (IncCA),
        .DecLen        (DecLen),
        .IncREUA       (IncREUA),
        .XferEnd       (XferEnd),
        .SetEndOfBlock (SetEndOfBlock),
        .SetVerifyErr  (SetVerifyErr),
        .CA            (CA),
        .REUA          (REUA),
        .nIRQ          (nIRQ)
    );

    always #5 PHI2 = ~PHI2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edgeWait();
        @(negedge PHI2);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        bus.nIO2 = 1'b0; bus.RnW = 1'b0; bus.A = a; bus.Din = d;
        edgeWait();
        bus.nIO2 = 1'b1; bus.RnW = 1'b1;
    endtask

    // holdThrough keeps the read active across the next falling edge.
    task automatic rdChk(input string tag, input logic [4:0] a, input logic [7:0] exp,
                         input bit holdThrough);
        bus.nIO2 = 1'b0; bus.RnW = 1'b1; bus.A = a;
        #1;
        chk(tag, {24'd0, bus.Dout}, {24'd0, exp});
        if (!holdThrough) bus.nIO2 = 1'b1;
        edgeWait();
        bus.nIO2 = 1'b1;
    endtask

    initial begin
        nRESET = 1'b1; FF00Wr = 1'b0; DMA = 1'b0;
        IncCA = 1'b0; DecLen = 1'b0; IncREUA = 1'b0; XferEnd = 1'b0;
        SetEndOfBlock = 1'b0; SetVerifyErr = 1'b0;
        bus.nIO2 = 1'b1; bus.RnW = 1'b1; bus.A = 5'h00; bus.Din = 8'h00;
        #2 nRESET = 1'b0;
        edgeWait(); edgeWait();
        nRESET = 1'b1;

        // Reset state
        chk("rst_execute", {31'd0, Execute}, 32'd0);
        chk("rst_nirq", {31'd0, nIRQ}, 32'd1);
        chk("rst_ca", {16'd0, CA}, 32'h0);
        chk("rst_reua", {13'd0, REUA}, 32'h0);
        chk("rst_length1", {31'd0, Length1}, 32'd0);
        rdChk("rst_status", 5'h00, 8'h10, 1'b0);
        rdChk("rst_cmd", 5'h01, 8'h1C, 1'b0);
        rdChk("rst_len_lo", 5'h07, 8'hFF, 1'b0);
        rdChk("rst_len_hi", 5'h08, 8'hFF, 1'b0);
        rdChk("rst_bank", 5'h06, 8'hF8, 1'b0);
        rdChk("rst_mask", 5'h09, 8'h1F, 1'b0);
        rdChk("rst_ctrl", 5'h0A, 8'h3F, 1'b0);
        rdChk("unused_0b", 5'h0B, 8'hFF, 1'b0);
        rdChk("unused_1f", 5'h1F, 8'hFF, 1'b0);

        // Immediate execute
        wr(5'h01, 8'h90);
        chk("imm_execute", {31'd0, Execute}, 32'd1);
        chk("imm_type", {30'd0, XferType}, 32'd0);
        XferEnd = 1'b1; edgeWait(); XferEnd = 1'b0;
        chk("imm_end_execute", {31'd0, Execute}, 32'd0);
        rdChk("imm_end_cmd", 5'h01, 8'h1C, 1'b0);

        // Armed execute via $FF00, length/CA counting
        wr(5'h07, 8'h02); wr(5'h08, 8'h00); wr(5'h02, 8'h00); wr(5'h03, 8'hC0);
        chk("ca_load", {16'd0, CA}, 32'hC000);
        chk("len2_length1", {31'd0, Length1}, 32'd0);
        wr(5'h01, 8'h81);
        chk("armed_execute", {31'd0, Execute}, 32'd0);
        chk("armed_type", {30'd0, XferType}, 32'd1);
        FF00Wr = 1'b1; edgeWait(); FF00Wr = 1'b0;
        chk("ff00_execute", {31'd0, Execute}, 32'd1);
        DMA = 1'b1;
        bus.nIO2 = 1'b0; #1;
        chk("doe_dma", {31'd0, bus.DOE}, 32'd0);
        bus.nIO2 = 1'b1;
        DecLen = 1'b1; IncCA = 1'b1; edgeWait(); DecLen = 1'b0; IncCA = 1'b0;
        chk("dec_length1", {31'd0, Length1}, 32'd1);
        chk("inc_ca", {16'd0, CA}, 32'hC001);
        XferEnd = 1'b1; edgeWait(); XferEnd = 1'b0; DMA = 1'b0;
        chk("end_execute", {31'd0, Execute}, 32'd0);
        chk("end_noautoload_ca", {16'd0, CA}, 32'hC001);
        rdChk("end_cmd", 5'h01, 8'h1D, 1'b0);
        FF00Wr = 1'b1; edgeWait(); FF00Wr = 1'b0;
        chk("disarmed_execute", {31'd0, Execute}, 32'd0);

        // Autoload with REUA wrap across the bank
        wr(5'h04, 8'hFF); wr(5'h05, 8'hFF); wr(5'h06, 8'h07);
        chk("reua_load", {13'd0, REUA}, 32'h7FFFF);
        rdChk("bank_read", 5'h06, 8'hFF, 1'b0);
        wr(5'h01, 8'hB0);
        chk("auto_execute", {31'd0, Execute}, 32'd1);
        DMA = 1'b1;
        IncREUA = 1'b1; edgeWait();
        chk("reua_wrap", {13'd0, REUA}, 32'h00000);
        edgeWait(); edgeWait(); IncREUA = 1'b0;
        chk("reua_plus2", {13'd0, REUA}, 32'h00002);
        XferEnd = 1'b1; edgeWait(); XferEnd = 1'b0; DMA = 1'b0;
        chk("reload_reua", {13'd0, REUA}, 32'h7FFFF);
        chk("reload_ca", {16'd0, CA}, 32'hC000);
        chk("reload_length1", {31'd0, Length1}, 32'd0);
        rdChk("auto_cmd", 5'h01, 8'h3C, 1'b0);
        IncCA = 1'b1; XferEnd = 1'b1; edgeWait(); IncCA = 1'b0; XferEnd = 1'b0;
        chk("reload_beats_inc", {16'd0, CA}, 32'hC000);
        wr(5'h01, 8'h00);
        IncCA = 1'b1; XferEnd = 1'b1; edgeWait(); IncCA = 1'b0; XferEnd = 1'b0;
        chk("inc_without_autoload", {16'd0, CA}, 32'hC001);
        rdChk("cmd_after_end", 5'h01, 8'h1C, 1'b0);

        // Length 1 -> 0 -> $FFFF
        wr(5'h07, 8'h01);
        chk("len1", {31'd0, Length1}, 32'd1);
        DecLen = 1'b1; edgeWait(); DecLen = 1'b0;
        chk("len0_length1", {31'd0, Length1}, 32'd0);
        rdChk("len0_lo", 5'h07, 8'h00, 1'b0);
        DecLen = 1'b1; edgeWait(); DecLen = 1'b0;
        rdChk("lenffff_lo", 5'h07, 8'hFF, 1'b0);
        rdChk("lenffff_hi", 5'h08, 8'hFF, 1'b0);

        // Interrupts and status clear-on-read
        wr(5'h09, 8'hE0);
        rdChk("mask_read", 5'h09, 8'hFF, 1'b0);
        SetVerifyErr = 1'b1; edgeWait(); SetVerifyErr = 1'b0;
        chk("verr_nirq", {31'd0, nIRQ}, 32'd0);
        rdChk("verr_status", 5'h00, 8'hB0, 1'b1);
        chk("cleared_nirq", {31'd0, nIRQ}, 32'd1);
        rdChk("cleared_status", 5'h00, 8'h10, 1'b0);
        bus.nIO2 = 1'b0; bus.RnW = 1'b1; bus.A = 5'h00; SetEndOfBlock = 1'b1;
        edgeWait();
        bus.nIO2 = 1'b1; SetEndOfBlock = 1'b0;
        chk("set_wins_nirq", {31'd0, nIRQ}, 32'd0);
        rdChk("set_wins_status", 5'h00, 8'hD0, 1'b1);
        rdChk("eob_cleared", 5'h00, 8'h10, 1'b0);
        wr(5'h09, 8'h60);
        rdChk("mask_noen", 5'h09, 8'h7F, 1'b0);
        SetVerifyErr = 1'b1; edgeWait(); SetVerifyErr = 1'b0;
        chk("masked_nirq", {31'd0, nIRQ}, 32'd1);
        rdChk("masked_status", 5'h00, 8'h30, 1'b1);
        rdChk("masked_cleared", 5'h00, 8'h10, 1'b0);

        // Fixed addresses
        wr(5'h0A, 8'h80);
        rdChk("ctrl_read", 5'h0A, 8'hBF, 1'b0);
        IncCA = 1'b1; IncREUA = 1'b1; edgeWait(); edgeWait(); IncCA = 1'b0; IncREUA = 1'b0;
        chk("fix_ca", {16'd0, CA}, 32'hC001);
        chk("free_reua", {13'd0, REUA}, 32'h00001);
        wr(5'h0A, 8'h40);
        IncCA = 1'b1; IncREUA = 1'b1; edgeWait(); IncCA = 1'b0; IncREUA = 1'b0;
        chk("free_ca", {16'd0, CA}, 32'hC002);
        chk("fix_reua", {13'd0, REUA}, 32'h00001);

        // Reset in the middle of a transfer
        wr(5'h01, 8'h90);
        chk("mid_execute", {31'd0, Execute}, 32'd1);
        DMA = 1'b1;
        DecLen = 1'b1; edgeWait(); DecLen = 1'b0;
        #2 nRESET = 1'b0;
        #1;
        chk("async_execute", {31'd0, Execute}, 32'd0);
        chk("async_ca", {16'd0, CA}, 32'h0);
        DMA = 1'b0;
        rdChk("async_len_lo", 5'h07, 8'hFF, 1'b0);
        rdChk("async_len_hi", 5'h08, 8'hFF, 1'b0);
        rdChk("async_cmd", 5'h01, 8'h1C, 1'b0);
        nRESET = 1'b1;
        edgeWait();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
